seg7_scan_drv: RTL

//  Parametrised, time-multiplexed N-digit 7-segment driver. Successor to the static per-digit LUT bank.

---
 rtl/seg7_scan_drv.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: N-digit multiplexed 7-segment driver with double-buffered display data; SEG7_LZB_EN adds leading-zero blanking.
// All pins registered one cycle after prescaler/index state; no backpressure, iLOAD is always accepted.
module seg7_scan_drv #(
  parameter int NUM_DIG     = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int GHOST       = 16,
  parameter int COM_ACT_LOW = 1
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [4*NUM_DIG-1:0]   iDIG,
  input  logic [NUM_DIG-1:0]     iDP,
  input  logic [NUM_DIG-1:0]     iBLANK,
  input  logic                   iLOAD,
  output logic [6:0]             oSEG,
  output logic                   oDP,
  output logic [NUM_DIG-1:0]     oCOM,
  output logic                   oFRAME
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIG);
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_GHOST = PW'(GHOST);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] COM_OFF = (COM_ACT_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [4*NUM_DIG-1:0]   pend_dig, act_dig;
  logic [NUM_DIG-1:0]     pend_dp, act_dp;
  logic [NUM_DIG-1:0]     pend_blank, act_blank;
  logic                   pend_valid;

  logic                   slot_end, frame_wrap;
  logic [NUM_DIG-1:0]     com_sel, dark;
  logic [3:0]             cur_nib;
  logic                   cur_dp, cur_dark;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0: seg_enc = 7'h40;
      4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;
      4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;
      4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;
      4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;
      4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;
      4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;
      4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;
      default: seg_enc = 7'h0E;
    endcase
  endfunction

  assign slot_end   = (presc == P_LAST);
  assign frame_wrap = slot_end && (idx == I_LAST);

`ifdef SEG7_LZB_EN
  logic lead;
  // Walk from the most significant digit; a lit DP or any non-zero nibble ends the leading run.
  always_comb begin
    lead = 1'b1;
    dark = '0;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      dark[k] = act_blank[k] |
                (lead && (act_dig[4*k +: 4] == 4'h0) && !act_dp[k] && (k != 0));
      lead    = lead && (((act_dig[4*k +: 4] == 4'h0) && !act_dp[k]) || act_blank[k]);
    end
  end
`else
  assign dark = act_blank;
`endif

  always_comb begin
    com_sel  = '0;
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (idx == IW'(k)) begin
        com_sel[k] = 1'b1;
        cur_nib    = act_dig[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_dark   = dark[k];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      presc      <= '0;
      idx        <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      oSEG       <= 7'h7F;
      oDP        <= 1'b1;
      oCOM       <= COM_OFF;
      oFRAME     <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end)
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;

      // A load coinciding with the wrap bypasses pending so it is never a frame late.
      if (iLOAD && frame_wrap) begin
        act_dig    <= iDIG;
        act_dp     <= iDP;
        act_blank  <= iBLANK;
        pend_valid <= 1'b0;
      end else if (iLOAD) begin
        pend_dig   <= iDIG;
        pend_dp    <= iDP;
        pend_blank <= iBLANK;
        pend_valid <= 1'b1;
      end else if (frame_wrap && pend_valid) begin
        act_dig    <= pend_dig;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        pend_valid <= 1'b0;
      end

      oFRAME <= frame_wrap;
      if (presc < P_GHOST) begin
        oCOM <= COM_OFF;
        oSEG <= 7'h7F;
        oDP  <= 1'b1;
      end else begin
        oCOM <= (COM_ACT_LOW != 0) ? ~com_sel : com_sel;
        oSEG <= cur_dark ? 7'h7F : seg_enc(cur_nib);
        oDP  <= ~(cur_dp & ~cur_dark);
      end
    end
  end

endmodule
